// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Consumes the decode-stage trap strobes, arbitrates simultaneous traps by
// fixed priority (tag > gs > ovf > trap_instr), captures cause and faulting
// PC, drives a timed pipeline flush and then offers the trap vector to fetch
// over a valid/ready handshake. While a trap is in service, new trap strobes
// are collected as sticky pending bits and replayed on return-from-exception.
// Also owns the squash of the instruction following a taken conditional skip.
//
// Optional feature: define TRAP_COUNT_EN to get four 16-bit saturating
// per-cause accept counters, readable through cnt_sel_i / cnt_o.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   tag_trap_i     tag trap strobe
//   gs_trap_i      guard/sign trap strobe
//   ovf_trap_i     overflow/underflow trap strobe
//   trap_instr_i   explicit trap instruction strobe
//   skip_en_i      conditional-skip instruction in decode
//   skip_cond_i    skip condition true (qualifies skip_en_i)
//   pc_i           PC of the instruction in decode
//   instr_valid_i  next instruction accepted into decode
//   rfe_i          return-from-exception pulse
//   vec_ready_i    fetch accepts the vector
//   flush_o        kill all in-flight pipeline stages
//   vec_valid_o    trap vector offered to fetch
//   vec_addr_o     trap vector address (VEC_BASE + cause*16)
//   cause_o        latched cause: 0 none, 1 tag, 2 gs, 3 ovf, 4 trap instr
//   epc_o          latched faulting PC
//   in_trap_o      trap in service (every state except IDLE)
//   squash_o       nullify the instruction following a taken skip
//   cnt_sel_i      counter select (0 tag, 1 gs, 2 ovf, 3 trap instr)
//   cnt_o          selected trap counter (0 when TRAP_COUNT_EN is undefined)
// All outputs are registered.
// -----------------------------------------------------------------------------
module trap_sequencer #(
    parameter int unsigned     PC_W         = 32,
    parameter int unsigned     FLUSH_CYCLES = 3,
    parameter logic [PC_W-1:0] VEC_BASE     = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tag_trap_i,
    input  logic            gs_trap_i,
    input  logic            ovf_trap_i,
    input  logic            trap_instr_i,
    input  logic            skip_en_i,
    input  logic            skip_cond_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            instr_valid_i,
    input  logic            rfe_i,
    input  logic            vec_ready_i,
    output logic            flush_o,
    output logic            vec_valid_o,
    output logic [PC_W-1:0] vec_addr_o,
    output logic [2:0]      cause_o,
    output logic [PC_W-1:0] epc_o,
    output logic            in_trap_o,
    output logic            squash_o,
    input  logic [1:0]      cnt_sel_i,
    output logic [15:0]     cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_VECTOR,
        ST_SERVICE
    } state_t;

    // Request vector bit order is priority order: bit 0 (tag) wins.
    function automatic logic [2:0] pick_cause(input logic [3:0] req);
        logic [2:0] c;
        c = 3'd0;
        if (req[0])      c = 3'd1;
        else if (req[1]) c = 3'd2;
        else if (req[2]) c = 3'd3;
        else if (req[3]) c = 3'd4;
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic [2:0]      cause_q, cause_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [3:0]      pend_q, pend_d;
    logic            skip_pend_q, skip_pend_d;
    logic            flush_q, flush_d;
    logic            vec_valid_q, vec_valid_d;
    logic [PC_W-1:0] vec_addr_q, vec_addr_d;
    logic            in_trap_q, in_trap_d;
    logic            squash_q, squash_d;

    logic [3:0]      strobes;
    logic [3:0]      pend_eff;
    logic            accept;
    logic [2:0]      accept_cause;

    assign strobes  = {trap_instr_i, ovf_trap_i, gs_trap_i, tag_trap_i};
    // Strobes arriving in the same cycle as rfe_i are folded in so they are
    // never lost on the way back to IDLE.
    assign pend_eff = pend_q | strobes;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        accept       = 1'b0;
        accept_cause = 3'd0;
        unique case (state_q)
            ST_IDLE: begin
                if (|strobes) begin
                    state_d      = ST_FLUSH;
                    accept       = 1'b1;
                    accept_cause = pick_cause(strobes);
                end
            end
            ST_FLUSH: begin
                if (fcnt_q <= 4'd1) state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                if (vec_valid_q && vec_ready_i) state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (rfe_i) begin
                    if (|pend_eff) begin
                        state_d      = ST_FLUSH;
                        accept       = 1'b1;
                        accept_cause = pick_cause(pend_eff);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------- outputs / datapath
    always_comb begin
        fcnt_d      = fcnt_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        pend_d      = pend_q;
        skip_pend_d = skip_pend_q;

        if (accept) begin
            fcnt_d  = 4'(FLUSH_CYCLES);
            cause_d = accept_cause;
            epc_d   = pc_i;
        end else if (state_q == ST_FLUSH) begin
            fcnt_d = fcnt_q - 4'd1;
        end

        if (state_q == ST_SERVICE && state_d == ST_IDLE) cause_d = 3'd0;

        // x & (x-1) drops the lowest set bit, i.e. the cause just replayed.
        if (state_q != ST_IDLE) begin
            if (state_q == ST_SERVICE && accept) pend_d = pend_eff & (pend_eff - 4'd1);
            else                                 pend_d = pend_eff;
        end

        if (accept)
            skip_pend_d = 1'b0;
        else if (state_q == ST_IDLE && skip_en_i && skip_cond_i)
            skip_pend_d = 1'b1;
        else if (instr_valid_i)
            skip_pend_d = 1'b0;

        squash_d    = skip_pend_q && instr_valid_i && !accept;
        flush_d     = (state_d == ST_FLUSH);
        vec_valid_d = (state_d == ST_VECTOR);
        vec_addr_d  = (state_d == ST_VECTOR)
                      ? VEC_BASE + ({{(PC_W-3){1'b0}}, cause_d} << 4)
                      : '0;
        in_trap_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q      <= '0;
            cause_q     <= '0;
            epc_q       <= '0;
            pend_q      <= '0;
            skip_pend_q <= 1'b0;
            flush_q     <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_addr_q  <= '0;
            in_trap_q   <= 1'b0;
            squash_q    <= 1'b0;
        end else begin
            fcnt_q      <= fcnt_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            pend_q      <= pend_d;
            skip_pend_q <= skip_pend_d;
            flush_q     <= flush_d;
            vec_valid_q <= vec_valid_d;
            vec_addr_q  <= vec_addr_d;
            in_trap_q   <= in_trap_d;
            squash_q    <= squash_d;
        end
    end

    assign flush_o     = flush_q;
    assign vec_valid_o = vec_valid_q;
    assign vec_addr_o  = vec_addr_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign in_trap_o   = in_trap_q;
    assign squash_o    = squash_q;

    // ------------------------------------------------------ trap counters
`ifdef TRAP_COUNT_EN
    logic [15:0] trap_cnt_q [4];
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: this small counter array is reset explicitly because its
        // values are architecturally visible; a large RAM would not be.
        if (rst) begin
            for (int i = 0; i < 4; i++) trap_cnt_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            if (accept && trap_cnt_q[2'(accept_cause - 3'd1)] != 16'hFFFF)
                trap_cnt_q[2'(accept_cause - 3'd1)] <= trap_cnt_q[2'(accept_cause - 3'd1)] + 16'd1;
            cnt_q <= trap_cnt_q[cnt_sel_i];
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel_i;
    assign cnt_o          = 16'd0;
`endif

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequential consumer of the decode-stage trap-condition strobes: the guard/sign trap, the tag trap, the overflow/underflow trap, the explicit trap instruction and the conditional-skip enable. Each cycle it samples those strobes, arbitrates between simultaneous traps by fixed priority, and captures the cause and faulting PC. It then drives a timed pipeline flush and hands the fetch unit a trap vector over a valid/ready handshake. It sits between the trap decode PLA and the fetch/PC-select logic, and also owns the squash of the instruction following a taken conditional skip.

## Interface
- FLUSH_CYCLES, 3: cycles `flush_o` is held per trap, range 1..15.
- VEC_BASE, 32'h0000_0100: trap vector base address.
- PC_W, 32: PC/vector width.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous and active-high.
- tag_trap_i  input  1  tag trap strobe, decode stage.
- gs_trap_i  input  1  guard/sign trap strobe.
- ovf_trap_i  input  1  overflow/underflow trap strobe.
- trap_instr_i  input  1  explicit trap instruction strobe.
- skip_en_i  input  1  conditional-skip instruction in decode.
- skip_cond_i  input  1  skip condition true, qualifies `skip_en_i`.
- pc_i  input  PC_W  PC of the instruction in decode.
- instr_valid_i  input  1  the next instruction is accepted into decode.
- rfe_i  input  1  return-from-exception, one-cycle pulse.
- vec_ready_i  input  1  fetch accepts the vector.
- flush_o  output  1  kill all in-flight pipeline stages.
- vec_valid_o  output  1  vector offered to fetch.
- vec_addr_o  output  PC_W  trap vector address.
- cause_o  output  3  latched cause: 0 none, 1 tag, 2 gs, 3 ovf, 4 trap instr.
- epc_o  output  PC_W  latched faulting PC.
- in_trap_o  output  1  trap in service; high from accept until `rfe_i`.
- squash_o  output  1  nullify the instruction currently being accepted.
- cnt_sel_i  input  2  counter select; only meaningful with TRAP_COUNT_EN.
- cnt_o  output  16  selected trap counter.

## Operation
- States: IDLE, FLUSH, VECTOR, SERVICE.
- **IDLE**
  - A trap is accepted if any trap strobe is high.
  - Priority: tag > gs > ovf > trap_instr.
  - On accept: latch `cause_o`, latch `epc_o <= pc_i`, load the flush counter with FLUSH_CYCLES, go to FLUSH.
  - Lower-priority strobes that are high in the same cycle are dropped; they are not made pending.
- **FLUSH**
  - `flush_o` = 1; the counter decrements each cycle.
  - At count 1, go to VECTOR.
- **VECTOR**
  - `vec_valid_o` = 1 and `vec_addr_o = VEC_BASE + (cause << 4)`, held stable until `vec_valid_o && vec_ready_i`.
  - After the handshake, go to SERVICE.
- **SERVICE**
  - Trap strobes set per-cause sticky pending bits (4 bits) instead of being accepted.
  - On `rfe_i`: if any pending bit is set, take the highest-priority pending cause, clear that bit, latch `epc_o <= pc_i`, go to FLUSH. Otherwise go to IDLE and set `cause_o` = 0.
- `in_trap_o` = 1 in every state except IDLE.
- Pending bits are also captured in FLUSH and VECTOR.
- `rfe_i` is ignored outside SERVICE.
- **Skip**
  - In IDLE, `skip_en_i && skip_cond_i` sets `skip_pend`.
  - On the next `instr_valid_i`, `squash_o` = 1 for that cycle only, and `skip_pend` clears.
  - Trap accept clears `skip_pend` in the same cycle; the trap wins.
  - A skip and `instr_valid_i` in the same cycle do not squash that same instruction.
- Vector arithmetic is modulo 2^PC_W.

## Timing
- Trap strobe sampled at edge T (IDLE).
  - `flush_o` is high for cycles T+1..T+FLUSH_CYCLES.
  - `vec_valid_o` rises at T+FLUSH_CYCLES+1.
- `cause_o`, `epc_o` and `in_trap_o` are valid from T+1.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: state IDLE, `flush_o` 0, `vec_valid_o` 0, `vec_addr_o` 0, `cause_o` 0, `epc_o` 0, `in_trap_o` 0, `squash_o` 0, pending 0, `skip_pend` 0, counters 0.
- Reset asserted mid-FLUSH or mid-VECTOR aborts immediately at the next edge; no handshake completes.

## Configuration
- TRAP_COUNT_EN defined:
  - Four 16-bit saturating counters, one per cause, each incremented on every accept (IDLE or pending re-entry) of that cause.
  - `cnt_o` shows the counter chosen by `cnt_sel_i` (0 tag, 1 gs, 2 ovf, 3 trap instr), registered, one cycle latency.
  - Counters hold at 16'hFFFF.
- TRAP_COUNT_EN undefined:
  - No counter registers exist.
  - `cnt_o` is constant 0 and `cnt_sel_i` is ignored.

## Test plan
- FLUSH_CYCLES=3; `gs_trap_i` and `trap_instr_i` both pulse at T with `pc_i`=32'h40 -> `cause_o`=2, `epc_o`=32'h40, `flush_o` high T+1..T+3, `vec_valid_o` at T+4, `vec_addr_o`=32'h120; trap_instr is dropped.
- `vec_ready_i` held low 5 cycles in VECTOR -> `vec_valid_o` and `vec_addr_o` stable throughout; SERVICE entered the cycle after `vec_ready_i` rises.
- In SERVICE, `ovf_trap_i` then `tag_trap_i` pulse; then `rfe_i` -> re-flush with `cause_o`=1 (vector 32'h110); after the next `rfe_i`, `cause_o`=3 (32'h130); after the third `rfe_i` -> IDLE, `cause_o`=0.
- In IDLE, `skip_en_i` and `skip_cond_i` at T, no `instr_valid_i` for 2 cycles, then `instr_valid_i` -> `squash_o` high exactly that one cycle; a skip followed by a tag trap -> no squash.
- `rst` pulsed in FLUSH cycle 2 -> next cycle all outputs at reset values; a new trap is accepted normally afterwards.
- With TRAP_COUNT_EN: 3 tag accepts, `cnt_sel_i`=0 -> `cnt_o`=3 one cycle later; counter preloaded to 16'hFFFF plus one accept stays 16'hFFFF. Without the macro: `cnt_o`=0.
